// File: rtl/stream_demux_if.sv
// Stream demultiplexer bus: one input stream and NUM_CH output streams.
// The slave view belongs to the demux, the master view to whoever drives it.
interface stream_demux_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
);
   logic [SEL_W-1:0]        sel_i;
   logic                    s_valid_i;
   logic                    s_ready_o;
   logic [WIDTH-1:0]        s_data_i;
   logic                    s_last_i;
   logic [NUM_CH-1:0]       m_valid_o;
   logic [NUM_CH-1:0]       m_ready_i;
   logic [NUM_CH*WIDTH-1:0] m_data_o;
   logic [NUM_CH-1:0]       m_last_o;

   modport slave (
      input  sel_i, s_valid_i, s_data_i, s_last_i, m_ready_i,
      output s_ready_o, m_valid_o, m_data_o, m_last_o
   );

   modport master (
      output sel_i, s_valid_i, s_data_i, s_last_i, m_ready_i,
      input  s_ready_o, m_valid_o, m_data_o, m_last_o
   );
endinterface

// File: rtl/stream_demux.sv
// Packet-level stream demux: the first beat picks a channel, the rest follow.
// Out-of-range selects drop the whole packet and flag err_o once.
module stream_demux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic busy_o,
   output logic err_o,
   stream_demux_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;

   localparam logic [SEL_W:0] NCH = NUM_CH[SEL_W:0];

   state_e state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d, tgt;
   logic [NUM_CH-1:0] vld_q, vld_d;
   logic [NUM_CH-1:0] last_q, last_d;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0][WIDTH-1:0] data_q, data_d;
   logic err_q, err_d;
   logic in_rng, drop, free, ready, acc;

   assign in_rng = {1'b0, bus.sel_i} < NCH;
   assign tgt    = (state_q == PKT) ? sel_q : bus.sel_i;
   assign drop   = (state_q == DROP) |
                   ((state_q == IDLE) & ~in_rng);

   // Target register can take a beat if empty or draining now
   always_comb begin
      free = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (tgt == SEL_W'(k)) begin
            free = ~vld_q[k] | bus.m_ready_i[k];
         end
      end
   end

   assign ready = en_i & ~rst_i & (drop | free);
   assign acc   = bus.s_valid_i & ready;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               if (!in_rng) begin
                  err_d = 1'b1;
                  if (!bus.s_last_i) state_d = DROP;
               end else if (!bus.s_last_i) begin
                  state_d = PKT;
                  sel_d   = bus.sel_i;
               end
            end
         end
         PKT, DROP: begin
            if (acc && bus.s_last_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         load[k]   = acc & ~drop & (tgt == SEL_W'(k));
         vld_d[k]  = load[k] |
                     (vld_q[k] & ~bus.m_ready_i[k]);
         data_d[k] = load[k] ? bus.s_data_i : data_q[k];
         last_d[k] = load[k] ? bus.s_last_i : last_q[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         vld_q   <= '0;
         last_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign bus.s_ready_o = ready;
   assign bus.m_valid_o = vld_q;
   assign bus.m_data_o  = data_q;
   assign bus.m_last_o  = last_q;
   assign busy_o        = (state_q != IDLE);
   assign err_o         = err_q;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: vector table, directed corner cases,
// and a randomized run against a packet-level reference model.
module tb_stream_demux;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, en_a, busy_a, err_a;
   logic rst_b, en_b, busy_b, err_b;

   stream_demux_if #(.WIDTH(8), .NUM_CH(4)) ifa ();
   stream_demux_if #(.WIDTH(8), .NUM_CH(3)) ifb ();

   stream_demux #(.WIDTH(8), .NUM_CH(4)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .en_i(en_a),
      .busy_o(busy_a), .err_o(err_a), .bus(ifa)
   );

   stream_demux #(.WIDTH(8), .NUM_CH(3)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .en_i(en_b),
      .busy_o(busy_b), .err_o(err_b), .bus(ifb)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic l);
      ifa.s_valid_i = v;
      ifa.sel_i     = s;
      ifa.s_data_i  = d;
      ifa.s_last_i  = l;
      #1;
   endtask

   task automatic drv_b(input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic l);
      ifb.s_valid_i = v;
      ifb.sel_i     = s;
      ifb.s_data_i  = d;
      ifb.s_last_i  = l;
      #1;
   endtask

   typedef struct {
      logic       vld;
      logic [1:0] sel;
      logic [7:0] d;
      logic       last;
      logic [3:0] mrdy;
      logic       srdy;
      logic [3:0] mvld;
      int         ch;
      logic [7:0] ed;
      logic       el;
      logic       busy;
   } vec_t;

   function automatic vec_t mk(
      input logic vld, input logic [1:0] sel,
      input logic [7:0] d, input logic last,
      input logic [3:0] mrdy, input logic srdy,
      input logic [3:0] mvld, input int ch,
      input logic [7:0] ed, input logic el,
      input logic busy);
      vec_t v;
      v.vld = vld; v.sel = sel; v.d = d; v.last = last;
      v.mrdy = mrdy; v.srdy = srdy; v.mvld = mvld;
      v.ch = ch; v.ed = ed; v.el = el; v.busy = busy;
      return v;
   endfunction

   vec_t tbl[6];

   // reference model state for dut_b
   logic [2:0] mv;
   logic [7:0] md[3];
   logic       ml[3];
   bit         in_pkt;
   int         dest;

   initial begin
      tbl[0] = mk(1'b1, 2'd2, 8'hA5, 1'b1, 4'hF, 1'b1,
                  4'b0100, 2, 8'hA5, 1'b1, 1'b0);
      tbl[1] = mk(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1,
                  4'b0000, 0, 8'h00, 1'b0, 1'b0);
      tbl[2] = mk(1'b1, 2'd1, 8'h11, 1'b0, 4'hF, 1'b1,
                  4'b0010, 1, 8'h11, 1'b0, 1'b1);
      tbl[3] = mk(1'b1, 2'd3, 8'h22, 1'b0, 4'hF, 1'b1,
                  4'b0010, 1, 8'h22, 1'b0, 1'b1);
      tbl[4] = mk(1'b1, 2'd3, 8'h33, 1'b1, 4'hF, 1'b1,
                  4'b0010, 1, 8'h33, 1'b1, 1'b0);
      tbl[5] = mk(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1,
                  4'b0000, 0, 8'h00, 1'b0, 1'b0);

      rst_a = 1'b1; en_a = 1'b1;
      rst_b = 1'b1; en_b = 1'b1;
      ifa.m_ready_i = 4'hF;
      ifb.m_ready_i = 3'h7;
      drv_a(1'b0, 2'd0, 8'h00, 1'b0);
      drv_b(1'b0, 2'd0, 8'h00, 1'b0);
      tick;
      chk("rst srdy", ifa.s_ready_o, 1'b0);
      tick;
      chk("rst mvld", ifa.m_valid_o, 4'h0);
      chk("rst mdata", ifa.m_data_o, 32'h0);
      chk("rst mlast", ifa.m_last_o, 4'h0);
      chk("rst busy", busy_a, 1'b0);
      chk("rst err", err_a, 1'b0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;

      for (int i = 0; i < 6; i++) begin
         ifa.m_ready_i = tbl[i].mrdy;
         drv_a(tbl[i].vld, tbl[i].sel, tbl[i].d, tbl[i].last);
         chk($sformatf("tbl%0d srdy", i), ifa.s_ready_o, tbl[i].srdy);
         tick;
         chk($sformatf("tbl%0d mvld", i), ifa.m_valid_o, tbl[i].mvld);
         if (tbl[i].mvld != 4'h0) begin
            chk($sformatf("tbl%0d data", i),
                ifa.m_data_o[tbl[i].ch*8 +: 8], tbl[i].ed);
            chk($sformatf("tbl%0d last", i),
                ifa.m_last_o[tbl[i].ch], tbl[i].el);
         end
         chk($sformatf("tbl%0d busy", i), busy_a, tbl[i].busy);
      end

      // backpressure on channel 0
      ifa.m_ready_i = 4'b1110;
      drv_a(1'b1, 2'd0, 8'h5A, 1'b1);
      chk("bp srdy1", ifa.s_ready_o, 1'b1);
      tick;
      chk("bp mvld1", ifa.m_valid_o, 4'b0001);
      chk("bp data1", ifa.m_data_o[7:0], 8'h5A);
      drv_a(1'b1, 2'd0, 8'hC3, 1'b1);
      chk("bp srdy stall", ifa.s_ready_o, 1'b0);
      tick;
      chk("bp hold data", ifa.m_data_o[7:0], 8'h5A);
      chk("bp hold vld", ifa.m_valid_o, 4'b0001);
      chk("bp srdy stall2", ifa.s_ready_o, 1'b0);
      ifa.m_ready_i = 4'hF;
      #1;
      chk("bp srdy release", ifa.s_ready_o, 1'b1);
      tick;
      chk("bp mvld2", ifa.m_valid_o, 4'b0001);
      chk("bp data2", ifa.m_data_o[7:0], 8'hC3);
      drv_a(1'b0, 2'd0, 8'h00, 1'b0);
      tick;
      chk("bp drained", ifa.m_valid_o, 4'h0);

      // enable dropped mid-packet
      ifa.m_ready_i = 4'b0111;
      drv_a(1'b1, 2'd3, 8'h01, 1'b0);
      tick;
      chk("en mvld1", ifa.m_valid_o, 4'b1000);
      chk("en data1", ifa.m_data_o[31:24], 8'h01);
      chk("en busy1", busy_a, 1'b1);
      en_a = 1'b0;
      drv_a(1'b1, 2'd0, 8'h02, 1'b0);
      ifa.m_ready_i = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("en low srdy", ifa.s_ready_o, 1'b0);
         tick;
         chk("en low drain", ifa.m_valid_o, 4'h0);
         chk("en low busy", busy_a, 1'b1);
      end
      en_a = 1'b1;
      #1;
      chk("en srdy back", ifa.s_ready_o, 1'b1);
      tick;
      chk("en mvld2", ifa.m_valid_o, 4'b1000);
      chk("en data2", ifa.m_data_o[31:24], 8'h02);
      chk("en last2", ifa.m_last_o[3], 1'b0);
      drv_a(1'b1, 2'd1, 8'h03, 1'b1);
      tick;
      chk("en mvld3", ifa.m_valid_o, 4'b1000);
      chk("en data3", ifa.m_data_o[31:24], 8'h03);
      chk("en last3", ifa.m_last_o[3], 1'b1);
      chk("en busy3", busy_a, 1'b0);
      drv_a(1'b0, 2'd0, 8'h00, 1'b0);
      tick;

      // reset mid-packet with outputs stalled
      ifa.m_ready_i = 4'h0;
      drv_a(1'b1, 2'd2, 8'h44, 1'b0);
      tick;
      chk("mr mvld1", ifa.m_valid_o, 4'b0100);
      drv_a(1'b1, 2'd2, 8'h45, 1'b0);
      chk("mr srdy stall", ifa.s_ready_o, 1'b0);
      rst_a = 1'b1;
      #1;
      chk("mr srdy in rst", ifa.s_ready_o, 1'b0);
      tick;
      chk("mr mvld", ifa.m_valid_o, 4'h0);
      chk("mr mdata", ifa.m_data_o, 32'h0);
      chk("mr mlast", ifa.m_last_o, 4'h0);
      chk("mr busy", busy_a, 1'b0);
      chk("mr err", err_a, 1'b0);
      rst_a = 1'b0;
      ifa.m_ready_i = 4'hF;
      drv_a(1'b1, 2'd0, 8'h77, 1'b1);
      chk("mr srdy new", ifa.s_ready_o, 1'b1);
      tick;
      chk("mr new mvld", ifa.m_valid_o, 4'b0001);
      chk("mr new data", ifa.m_data_o[7:0], 8'h77);
      chk("mr new busy", busy_a, 1'b0);
      drv_a(1'b0, 2'd0, 8'h00, 1'b0);

      // out-of-range select with three channels
      drv_b(1'b1, 2'd3, 8'hEE, 1'b0);
      chk("oor srdy1", ifb.s_ready_o, 1'b1);
      tick;
      chk("oor err1", err_b, 1'b1);
      chk("oor busy1", busy_b, 1'b1);
      chk("oor mvld1", ifb.m_valid_o, 3'h0);
      drv_b(1'b1, 2'd0, 8'hEF, 1'b1);
      chk("oor srdy2", ifb.s_ready_o, 1'b1);
      tick;
      chk("oor err2", err_b, 1'b0);
      chk("oor busy2", busy_b, 1'b0);
      chk("oor mvld2", ifb.m_valid_o, 3'h0);
      drv_b(1'b1, 2'd3, 8'hF0, 1'b1);
      tick;
      chk("oor single err", err_b, 1'b1);
      chk("oor single busy", busy_b, 1'b0);
      drv_b(1'b0, 2'd0, 8'h00, 1'b0);
      tick;
      chk("oor err clear", err_b, 1'b0);
      chk("oor mvld3", ifb.m_valid_o, 3'h0);

      // randomized run against the packet model
      rst_b = 1'b1;
      tick;
      rst_b = 1'b0;
      mv = '0;
      for (int k = 0; k < 3; k++) begin
         md[k] = 8'h00;
         ml[k] = 1'b0;
      end
      in_pkt = 1'b0;
      dest = 0;
      for (int c = 0; c < 800; c++) begin
         logic r, e, v, l, er, acc, exp_err;
         logic [1:0] s;
         logic [7:0] d;
         logic [2:0] mr;
         int dst;
         r  = ($urandom_range(0, 59) == 0);
         e  = ($urandom_range(0, 7) != 0);
         v  = ($urandom_range(0, 3) != 0);
         s  = 2'($urandom_range(0, 3));
         d  = 8'($urandom);
         l  = ($urandom_range(0, 3) == 0);
         mr = 3'($urandom_range(0, 7));
         rst_b = r;
         en_b  = e;
         ifb.m_ready_i = mr;
         drv_b(v, s, d, l);
         dst = in_pkt ? dest : int'(s);
         if (r || !e) er = 1'b0;
         else if (dst >= 3) er = 1'b1;
         else er = !mv[dst] || mr[dst];
         chk("rnd srdy", ifb.s_ready_o, er);
         acc = v && er;
         exp_err = 1'b0;
         if (r) begin
            mv = '0;
            for (int k = 0; k < 3; k++) begin
               md[k] = 8'h00;
               ml[k] = 1'b0;
            end
            in_pkt = 1'b0;
            dest = 0;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (mv[k] && mr[k]) mv[k] = 1'b0;
            end
            if (acc && dst < 3) begin
               mv[dst] = 1'b1;
               md[dst] = d;
               ml[dst] = l;
            end
            exp_err = acc && !in_pkt && (s >= 2'd3);
            if (acc) begin
               if (l) in_pkt = 1'b0;
               else if (!in_pkt) begin
                  in_pkt = 1'b1;
                  dest = (s >= 2'd3) ? 3 : int'(s);
               end
            end
         end
         tick;
         chk("rnd mvld", ifb.m_valid_o, mv);
         chk("rnd mdata", ifb.m_data_o, {md[2], md[1], md[0]});
         chk("rnd mlast", ifb.m_last_o, {ml[2], ml[1], ml[0]});
         chk("rnd busy", busy_b, in_pkt);
         chk("rnd err", err_b, exp_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8, data width of each beat in bits (1..64).
REQ-002 Parameter NUM_CH, default 4, number of output channels (2..16; need not be a power of 2).
REQ-003 Derived parameter SEL_W, default $clog2(NUM_CH) (2 for NUM_CH=4), width of sel_i.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 en_i  in  1  global enable; low blocks new acceptances.
REQ-007 sel_i  in  SEL_W  channel select, sampled on first beat of a packet only.
REQ-008 s_valid_i  in  1  input beat valid.
REQ-009 s_ready_o  out  1  input beat ready.
REQ-010 s_data_i  in  WIDTH  input beat data.
REQ-011 s_last_i  in  1  final beat of packet.
REQ-012 m_valid_o  out  NUM_CH  per-channel output valid.
REQ-013 m_ready_i  in  NUM_CH  per-channel output ready.
REQ-014 m_data_o  out  NUM_CH*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-015 m_last_o  out  NUM_CH  per-channel last flag.
REQ-016 busy_o  out  1  high while the FSM is not in IDLE.
REQ-017 err_o  out  1  one-cycle pulse on acceptance of an out-of-range first beat.

Function
REQ-018 An input beat is accepted in a cycle only when s_valid_i & s_ready_o are both high at the rising edge.
REQ-019 Each channel has one output register (data, last, valid); an output beat is transferred when m_valid_o[k] & m_ready_i[k] are both high.
REQ-020 FSM states: IDLE, PKT, DROP.
REQ-021 IDLE: target channel is sel_i; on an accepted beat with sel_i < NUM_CH and s_last_i=0, the block latches sel_i and moves to PKT.
REQ-022 IDLE: an accepted single-beat packet (s_last_i=1, sel_i in range) stays in IDLE.
REQ-023 PKT: target channel is the latched select, ignoring sel_i; an accepted beat with s_last_i=1 returns the FSM to IDLE.
REQ-024 IDLE with sel_i >= NUM_CH: s_ready_o = en_i; the accepted beat is discarded; err_o pulses for 1 cycle; FSM goes to DROP if s_last_i=0, else stays in IDLE.
REQ-025 DROP: s_ready_o = en_i; all beats are discarded without further err_o pulses; an accepted beat with s_last_i=1 returns the FSM to IDLE.
REQ-026 IDLE/PKT: s_ready_o = en_i & (~m_valid_o[t] | m_ready_i[t]) for target channel t; this term is combinational from m_ready_i.
REQ-027 Latency: a beat accepted at edge N is visible on m_valid_o/m_data_o/m_last_o of its target channel after edge N, i.e. in cycle N+1.
REQ-028 Throughput: one beat per cycle to a channel whose m_ready_i is held high.
REQ-029 Simultaneous drain and load on the same channel in one edge: the register loads the new beat and m_valid_o stays high.
REQ-030 Non-target channels drain independently of input activity.
REQ-031 en_i low: no acceptance (s_ready_o=0); FSM state and latched select are held; buffered outputs still drain.
REQ-032 m_data_o[k] and m_last_o[k] are held unchanged while m_valid_o[k]=1 and m_ready_i[k]=0.
REQ-033 At most one m_valid_o bit is set by any single acceptance; channels not loaded keep their contents.

Reset
REQ-034 rst_i high at an edge forces: FSM=IDLE, m_valid_o=0, m_data_o=0, m_last_o=0, err_o=0, busy_o=0, latched select=0.
REQ-035 Reset has priority over any simultaneous acceptance or drain.
REQ-036 Reset mid-packet or mid-drop discards all buffered beats, and no partial-packet state survives.
REQ-037 s_ready_o is 0 during every cycle in which rst_i is high.

Verification
REQ-038 Test 1, single beat: NUM_CH=4, WIDTH=8, en_i=1, sel_i=2, data=0xA5, last=1, all m_ready_i=1 -> m_valid_o=4'b0100 and m_data_o[23:16]=0xA5 for exactly one cycle, starting the cycle after acceptance; busy_o stays 0.
REQ-039 Test 2, packet lock: 3-beat packet 0x11,0x22,0x33 with sel_i=1 on beat 1 and sel_i=3 on beats 2-3 -> all three beats appear on channel 1 in consecutive cycles; m_last_o[1]=1 only with 0x33; busy_o is high from the cycle after beat 1 until the cycle after beat 3.
REQ-040 Test 3, backpressure: m_ready_i[0]=0 with two beats to channel 0 -> first beat held on channel 0; s_ready_o=0 for the second beat; raising m_ready_i[0] drains beat 1 and accepts beat 2 at the same edge with no gap.
REQ-041 Test 4, out-of-range: NUM_CH=3, sel_i=3, 2-beat packet -> both beats accepted; err_o pulses once; m_valid_o stays 0; FSM returns to IDLE after beat 2.
REQ-042 Test 5, enable: en_i dropped mid-packet for 5 cycles -> s_ready_o=0 and the buffered beat still drains; after en_i rises the packet continues on the latched channel.
REQ-043 Test 6, reset mid-packet: rst_i asserted after beat 2 of a 4-beat packet with m_ready_i=0 -> next cycle all outputs are 0 and FSM is IDLE; a new packet with sel_i=0 routes to channel 0.
